// File: rtl/apb_slave_regbank_pkg.sv
// Shared types, register offsets and decode helper for the APB scratch-register target.
package apb_regbank_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WCNT_W = 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT} apb_state_e;

  localparam logic [ADDR_W-1:0] STATUS_OFF = 8'h40;
  localparam logic [ADDR_W-1:0] ERRCNT_OFF = 8'h44;
  localparam logic [ADDR_W-1:0] ID_OFF     = 8'h48;
  localparam logic [DATA_W-1:0] ID_BASE    = 32'hA9B0_0000;

  typedef struct packed {
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
  } status_t;

  // 1 when the access must be answered with PSLVERR (unaligned, unmapped, or write to RO)
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input logic wr,
                                    input int unsigned nregs);
    if (a[1:0] != 2'b00) return 1'b1;
    if (32'(a[ADDR_W-1:2]) < nregs) return 1'b0;
    if (a == STATUS_OFF || a == ERRCNT_OFF || a == ID_OFF) return wr;
    return 1'b1;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus between the bridge (master) and one peripheral target (slave).
interface apb_slave_regbank_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata,
                  input  Prdata, Pready, Pslverr);
  modport slave  (input  Pselx, Penable, Pwrite, Paddr, Pwdata,
                  output Prdata, Pready, Pslverr);
endinterface

// File: rtl/apb_slave_regbank_fsm.sv
// APB phase tracker: setup/commit strobes, protocol-error detection, optional wait counter.
// Wait states are built only when APB_WAIT_EN is defined.
module apb_slave_fsm
  import apb_regbank_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              bad_c,
  output logic              setup_pulse,
  output logic              commit_pulse,
  output logic              proto_err,
  output logic [ADDR_W-1:0] addr_q,
  output logic              wr_q,
  output logic              pready,
  output logic              pslverr
);

  apb_state_e state_q, state_d;
  logic       mismatch_c;
  logic       pslverr_d;
`ifdef APB_WAIT_EN
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q;
  logic              pready_q;
`else
  localparam int unsigned unused_wait_states = WAIT_STATES;
`endif

  assign mismatch_c = !sel || (paddr != addr_q) || (pwrite != wr_q);

  always_comb begin
    state_d      = state_q;
    setup_pulse  = 1'b0;
    commit_pulse = 1'b0;
    proto_err    = 1'b0;
`ifdef APB_WAIT_EN
    wcnt_d       = wcnt_q;
`endif
    case (state_q)
      ACCESS: begin
        state_d = IDLE;
        if (mismatch_c) proto_err = 1'b1;
        else            commit_pulse = 1'b1;
      end
`ifdef APB_WAIT_EN
      WAIT: begin
        if (mismatch_c) begin
          proto_err = 1'b1;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
          if (wcnt_q == WCNT_W'(1)) state_d = ACCESS;
        end
      end
`endif
      default: if (sel && penable) proto_err = 1'b1;
    endcase
    // a new SETUP is taken from idle or in place of an access that broke protocol
    if ((state_q == IDLE || proto_err) && sel && !penable) begin
      setup_pulse = 1'b1;
`ifdef APB_WAIT_EN
      wcnt_d  = WCNT_W'(WAIT_STATES);
      state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
`else
      state_d = ACCESS;
`endif
    end
  end

`ifdef APB_WAIT_EN
  assign pslverr_d = (state_d == ACCESS) && (setup_pulse ? bad_c : err_q);
  assign pready    = pready_q;
`else
  assign pslverr_d = setup_pulse && bad_c;
  assign pready    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      pslverr  <= 1'b0;
`ifdef APB_WAIT_EN
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      pready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      pslverr <= pslverr_d;
      if (setup_pulse) begin
        addr_q <= paddr;
        wr_q   <= pwrite;
      end
`ifdef APB_WAIT_EN
      if (setup_pulse) err_q <= bad_c;
      wcnt_q   <= wcnt_d;
      pready_q <= (state_d != WAIT);
`endif
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB scratch-register target with STATUS/ERRCNT/ID read-only registers.
// Optional wait states: define APB_WAIT_EN.
module apb_slave_regbank
  import apb_regbank_pkg::*;
#(
  parameter int unsigned SLV_ID      = 0,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                Hclk,
  input logic                Hreset,
  apb_slave_regbank_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              sel;
  logic              bad_c;
  logic              setup_pulse;
  logic              commit_pulse;
  logic              proto_err;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] prdata_q;
  status_t           status_q;
  logic [7:0]        errcnt_q;
  logic              unused_bus;

  assign sel        = bus.Pselx[SLV_ID];
  assign bad_c      = addr_bad(bus.Paddr[ADDR_W-1:0], bus.Pwrite, NUM_REGS);
  assign unused_bus = ^{bus.Pselx, bus.Paddr[DATA_W-1:ADDR_W]};

  apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk          (Hclk),
    .rst          (Hreset),
    .sel          (sel),
    .penable      (bus.Penable),
    .pwrite       (bus.Pwrite),
    .paddr        (bus.Paddr[ADDR_W-1:0]),
    .bad_c        (bad_c),
    .setup_pulse  (setup_pulse),
    .commit_pulse (commit_pulse),
    .proto_err    (proto_err),
    .addr_q       (addr_q),
    .wr_q         (wr_q),
    .pready       (pready),
    .pslverr      (pslverr)
  );

  // read mux on the live SETUP address; counters read here are pre-increment
  always_comb begin
    rdata_c = '0;
    if (!addr_bad(bus.Paddr[ADDR_W-1:0], 1'b0, NUM_REGS)) begin
      if (bus.Paddr[ADDR_W-1:0] == STATUS_OFF)      rdata_c = DATA_W'(status_q);
      else if (bus.Paddr[ADDR_W-1:0] == ERRCNT_OFF) rdata_c = {24'h0, errcnt_q};
      else if (bus.Paddr[ADDR_W-1:0] == ID_OFF)     rdata_c = ID_BASE | DATA_W'(SLV_ID);
      else                                          rdata_c = regs_q[bus.Paddr[IDX_W+1:2]];
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      status_q <= '0;
      errcnt_q <= '0;
      prdata_q <= '0;
    end else begin
      if (commit_pulse && wr_q && !addr_bad(addr_q, 1'b1, NUM_REGS))
        regs_q[addr_q[IDX_W+1:2]] <= bus.Pwdata;
      if (commit_pulse) begin
        if (wr_q) status_q.wr_cnt <= status_q.wr_cnt + 16'd1;
        else      status_q.rd_cnt <= status_q.rd_cnt + 16'd1;
      end
      if (proto_err && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
      // read data is held only for the life of a read transfer
      if (setup_pulse)                   prdata_q <= bus.Pwrite ? '0 : rdata_c;
      else if (commit_pulse || proto_err) prdata_q <= '0;
    end
  end

  assign bus.Prdata  = prdata_q;
  assign bus.Pready  = pready;
  assign bus.Pslverr = pslverr;

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB responder (peripheral end) for the AHB-to-APB bridge.
- Decodes one bit of the bridge's Pselx bus and tracks the APB SETUP/ACCESS phases.
- Serves a bank of read/write scratch registers plus read-only access counters.
- Serves as the reference APB target for bridge integration and regression.

Parameters:
- SLV_ID, 0, index of the Pselx bit this instance answers to (0..2).
- NUM_REGS, 8, number of 32-bit RW scratch registers at offsets 0x00..(NUM_REGS-1)*4.
- WAIT_STATES, 1, number of Pready-low cycles per access; used only when APB_WAIT_EN is defined (0..7).

Ports:
- Hclk  in  1  single clock, shared with the bridge.
- Hreset  in  1  synchronous reset, active-high.
- Pselx  in  3  bridge slave selects; only bit SLV_ID is used.
- Penable  in  1  APB enable (ACCESS phase).
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address; only Paddr[7:0] is decoded.
- Pwdata  in  32  write data.
- Prdata  out  32  read data.
- Pready  out  1  transfer complete. Tied to 1 unless APB_WAIT_EN is defined.
- Pslverr  out  1  error response, valid while Pready=1 in ACCESS.

Behaviour:
- sel = Pselx[SLV_ID].
- FSM states: IDLE, SETUP, ACCESS. WAIT exists only with APB_WAIT_EN.
- Transitions:
  - IDLE -> SETUP when sel=1 and Penable=0.
  - SETUP -> ACCESS on the next cycle, unconditionally.
  - ACCESS (with Pready=1):
    - -> SETUP if sel=1 and Penable=0 (back-to-back transfer);
    - -> IDLE otherwise.
- SETUP cycle latches:
  - Paddr[7:0] into addr_q and Pwrite into wr_q;
  - for reads, registers the decoded read value into Prdata.
- Prdata:
  - valid from the ACCESS cycle (one cycle after SETUP) until the transfer completes;
  - forced to 0 in IDLE and after a write.
- Writes commit at the clock edge ending the ACCESS cycle with Pready=1. A write is visible to a read issued in the next SETUP.
- Register map:
  - 0x00..(NUM_REGS-1)*4: RW scratch registers.
  - 0x40 STATUS (RO): [15:0] completed-write count, [31:16] completed-read count.
  - 0x44 ERRCNT (RO): [7:0] protocol-error count.
  - 0x48 ID (RO): 32'hA9B0_0000 | SLV_ID.
  - Counters wrap modulo 2^16 (STATUS) and saturate at 8'hFF (ERRCNT).
- Out-of-map or unaligned address (Paddr[1:0] != 0), or a write to an RO register:
  - Pslverr=1 during ACCESS;
  - write dropped; read returns 0;
  - the transfer is still counted in STATUS.
- Protocol errors (increment ERRCNT, no register update):
  - Penable=1 while in IDLE;
  - sel drops during ACCESS;
  - Paddr[7:0] or Pwrite differs in ACCESS from the value latched in SETUP.
  - Recovery: FSM returns to IDLE, or to SETUP if sel=1 and Penable=0.
- Simultaneous events: a STATUS counter increment and a read of STATUS in the same SETUP return the pre-increment value.
- Reset (synchronous, highest priority):
  - FSM to IDLE; all scratch registers, counters, Prdata and Pslverr to 0; Pready=1.
  - Reset asserted mid-transfer aborts the transfer with no write.

Optional Feature:
- Macro: APB_WAIT_EN.
- Defined:
  - On entry to ACCESS a counter loads WAIT_STATES. Pready=0 while the counter is nonzero (state WAIT); then Pready=1 for one cycle.
  - Write commit, Pslverr and counting occur only on the Pready=1 cycle.
  - WAIT_STATES=0 behaves as if undefined.
- Undefined: Pready is constant 1; no WAIT state and no wait counter.

Decomposition:
- Package apb_regbank_pkg holds:
  - enum apb_state_e {IDLE, SETUP, ACCESS, WAIT};
  - offset constants STATUS_OFF=8'h40, ERRCNT_OFF=8'h44, ID_OFF=8'h48;
  - ID_BASE=32'hA9B0_0000.
- One sub-module, apb_slave_fsm: phase tracking, protocol-error detection and wait counter. It outputs setup_pulse, commit_pulse and proto_err to the register bank in the top.

Test Plan:
- Reset, then read 0x48 with SLV_ID=1 -> Prdata=32'hA9B0_0001 in ACCESS; Pslverr=0.
- Write 0x04=32'hDEAD_BEEF, then read 0x04 back-to-back (no IDLE between) -> Prdata=32'hDEAD_BEEF; STATUS reads 32'h0001_0001 on the following read.
- Write 0x40 and read 0x50 -> Pslverr=1 on both; STATUS write count increments; scratch registers unchanged; read data 0.
- Change Paddr from 0x08 to 0x0C between SETUP and ACCESS of a write -> no register written; ERRCNT=1.
- APB_WAIT_EN with WAIT_STATES=3: write 0x00=32'h1234_5678 -> Pready low for 3 cycles, then high for 1; register updates only after the Pready-high edge.
- Assert Hreset during the ACCESS cycle of a write to 0x08=32'hFFFF_FFFF -> 0x08 reads 0; STATUS=0; FSM in IDLE.
